z80_pad_ctrl: RTL and testbench
===============================

# z80_pad_ctrl

Pad-side control stage between the ChipIgnite user I/O pins and the `z80` core. It synchronises the four asynchronous control inputs (/WAIT, /INT, /NMI, /BUSRQ) and stretches reset into the core. It also generates the output-enable-bar vectors for the control, address and data pin groups. Address, data and /MREQ, /IORQ, /RD, /WR are floated during reset and while the bus is granted (/BUSAK low), as the Z80 datasheet requires.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop stages per input synchroniser. Legal range 2–3.
- `RST_HOLD`, default 3: cycles `core_reset_n` stays low after `rst_n` rises. Legal range 1–15.
- `TURNAROUND`, default 0: extra float cycles after /BUSAK deasserts. Legal range 0–3.

Ports:
- `wb_clk_i`  in  1  the single clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pad_wait_n`, `pad_int_n`, `pad_nmi_n`, `pad_busrq_n`  in  1 each  raw pins io_in[34], [32], [33], [35].
- `core_wait_n`, `core_int_n`, `core_nmi_n`, `core_busrq_n`  out  1 each  synchronised copies fed to the core.
- `core_reset_n`  out  1  stretched reset to the core.
- `core_busak_n`  in  1  /BUSAK from the core.
- `core_doe`  in  1  core data-write enable.
- `io_oeb_ctrl`  out  8  oeb for io[7:0].
- `io_oeb_addr`  out  16  oeb for io[23:8].
- `io_oeb_data`  out  8  oeb for io[31:24].
- `bus_floating`  out  1  high while the address, data and float-control groups are released.

## Operation
- **Synchronisers:** each pad input passes through a `SYNC_STAGES` flop chain. All flops reset to 1 (inactive).
- **State machine:** one of RST, RUN, FLOAT, RECLAIM; a 4-bit down-counter is shared by RST and RECLAIM.
  - **RST:** entered from any state on the cycle after `rst_n` is sampled 0.
    - The counter loads `RST_HOLD` every cycle that `rst_n` is 0.
    - Once `rst_n` is 1, the counter decrements each cycle; at 0 the FSM goes to RUN.
    - `core_busak_n` is ignored in RST.
  - **RUN:** `core_busak_n` sampled 0 moves the FSM to FLOAT.
  - **FLOAT:** `core_busak_n` sampled 1 moves the FSM to RECLAIM (counter loads `TURNAROUND`); with `TURNAROUND`=0 it goes straight to RUN.
  - **RECLAIM:** counts down to 0, then goes to RUN. `core_busak_n` sampled 0 during RECLAIM returns the FSM to FLOAT.
- **Outputs:**
  - `core_reset_n`: registered; equals 0 exactly while in RST.
  - `bus_floating`: registered; 1 in RST, FLOAT and RECLAIM.
  - `io_oeb_addr`: `{16{bus_floating}}`.
  - `io_oeb_ctrl`: bits 3–6 (/MREQ, /IORQ, /RD, /WR) equal `bus_floating`; bits 0, 1, 2, 7 (/HALT, /BUSAK, /M1, /RFSH) are always 0.
  - `io_oeb_data`: `{8{~(core_doe & ~bus_floating)}}`. This path is combinational from `core_doe`; the data bus drives only on writes in RUN.

## Timing
- **Reset values:**
  - FSM = RST, `core_reset_n`=0, `bus_floating`=1.
  - `io_oeb_addr`=16'hFFFF, `io_oeb_ctrl`=8'h78, `io_oeb_data`=8'hFF.
  - Every `core_*` synchronised output = 1.
- **Input latency:** a pad edge appears on the `core_*` output `SYNC_STAGES` cycles later.
- **Reset release:** `core_reset_n` rises `RST_HOLD` cycles after the first cycle `rst_n` is sampled 1.
- **Bus grant and return:**
  - /BUSAK low → float one cycle later.
  - /BUSAK high → drive 1+`TURNAROUND` cycles later.
- **Data enable:** `io_oeb_data` tracks `core_doe` in the same cycle, with no register.
- **Simultaneous events:** `rst_n`=0 overrides everything, including a /BUSAK change in the same cycle.
- **Reset pulses:** a 1-cycle `rst_n` pulse still yields the full `RST_HOLD` stretch.

## Configuration
- Macro: `Z80_PAD_BUS_FLOAT_EN`.
- **Defined:** behaviour exactly as above.
- **Undefined:**
  - The FSM keeps only RST/RUN.
  - `io_oeb_addr`=0 and `io_oeb_ctrl`=0 at all times, including reset.
  - `io_oeb_data`=`{8{~core_doe}}`.
  - `bus_floating`=0.
  - Synchronisers and the reset stretch are unchanged.

## Structure
- **Package `z80_pad_pkg`:**
  - FSM state enum.
  - Group widths (CTRL=8, ADDR=16, DATA=8).
  - `FLOAT_CTRL_MASK` = 8'h78.
  - Counter width (4).
- **Sub-module `z80_sync_chain`:** single-bit synchroniser with parameters `STAGES` and `RESET_VAL`, instantiated four times.

## Test plan
- **Reset stretch:** hold `rst_n`=0 for 5 cycles, then release. `core_reset_n` must stay 0 for exactly 3 more cycles. `io_oeb_addr`=16'hFFFF and `io_oeb_ctrl`=8'h78 throughout.
- **Sync latency:** in RUN, drop `pad_int_n` at cycle N. `core_int_n` must fall at N+2; a 1-cycle glitch must also propagate as a 1-cycle pulse.
- **Bus grant:**
  - Drive `core_busak_n`=0 in RUN. The next cycle must show `bus_floating`=1, `io_oeb_addr`=16'hFFFF, `io_oeb_ctrl`=8'h78.
  - Release `core_busak_n`. The next cycle must show 16'h0000 and 8'h00.
  - Repeat with `TURNAROUND`=2: driving resumes 3 cycles after release.
- **Data direction:**
  - In RUN, `core_doe`=1 must give `io_oeb_data`=8'h00 in the same cycle.
  - In FLOAT, `core_doe`=1 must give 8'hFF.
- **Reset mid-grant:** assert `rst_n`=0 while in FLOAT. Next cycle the FSM must be in RST and `core_reset_n`=0, with groups still floated. After release and the stretch, the FSM must reach RUN even though /BUSAK stays low until the core resets.
- **Macro undefined:** hold `core_busak_n`=0. `io_oeb_addr` must remain 16'h0000 and `bus_floating` must remain 0.

Source files
------------

// File: rtl/z80_pad_pkg.sv
// Shared types and constants for the z80 pad control stage.
package z80_pad_pkg;

    localparam int CTRL_W = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    // /MREQ, /IORQ, /RD, /WR occupy io[6:3] and are the only control pins that float.
    localparam logic [CTRL_W-1:0] FLOAT_CTRL_MASK = 8'h78;

    typedef enum logic [1:0] {
        ST_RST,
        ST_RUN,
        ST_FLOAT,
        ST_RECLAIM
    } pad_state_e;

endpackage

// File: rtl/z80_pad_if.sv
// Bus-direction signals between the pad control stage and the core/pad ring.
interface z80_pad_if;
    import z80_pad_pkg::*;

    logic              core_busak_n;
    logic              core_doe;
    logic [CTRL_W-1:0] io_oeb_ctrl;
    logic [ADDR_W-1:0] io_oeb_addr;
    logic [DATA_W-1:0] io_oeb_data;
    logic              bus_floating;

    modport master (
        input  core_busak_n,
        input  core_doe,
        output io_oeb_ctrl,
        output io_oeb_addr,
        output io_oeb_data,
        output bus_floating
    );

    modport slave (
        output core_busak_n,
        output core_doe,
        input  io_oeb_ctrl,
        input  io_oeb_addr,
        input  io_oeb_data,
        input  bus_floating
    );

endinterface

// File: rtl/z80_sync_chain.sv
// Single-bit flop-chain synchroniser with a configurable depth and reset value.
module z80_sync_chain
    import z80_pad_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/z80_pad_ctrl.sv
// Pad-side control for the z80 core: input synchronisers, reset stretch and pad output-enables.
// Floating the bus on /BUSAK is built only when Z80_PAD_BUS_FLOAT_EN is defined.
module z80_pad_ctrl
    import z80_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RST_HOLD    = 3,
    parameter int TURNAROUND  = 0
) (
    input  logic      wb_clk_i,
    input  logic      rst_n,
    input  logic      pad_wait_n,
    input  logic      pad_int_n,
    input  logic      pad_nmi_n,
    input  logic      pad_busrq_n,
    output logic      core_wait_n,
    output logic      core_int_n,
    output logic      core_nmi_n,
    output logic      core_busrq_n,
    output logic      core_reset_n,
    z80_pad_if.master bus
);

    localparam logic [CNT_W-1:0] RST_HOLD_C = CNT_W'(RST_HOLD);

    pad_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resetN_q;

    z80_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wait (
        .clk_i (wb_clk_i),
        .rst_ni(rst_n),
        .d_i   (pad_wait_n),
        .q_o   (core_wait_n)
    );

    z80_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_int (
        .clk_i (wb_clk_i),
        .rst_ni(rst_n),
        .d_i   (pad_int_n),
        .q_o   (core_int_n)
    );

    z80_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nmi (
        .clk_i (wb_clk_i),
        .rst_ni(rst_n),
        .d_i   (pad_nmi_n),
        .q_o   (core_nmi_n)
    );

    z80_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_busrq (
        .clk_i (wb_clk_i),
        .rst_ni(rst_n),
        .d_i   (pad_busrq_n),
        .q_o   (core_busrq_n)
    );

`ifdef Z80_PAD_BUS_FLOAT_EN
    localparam logic [CNT_W-1:0] TA_C = CNT_W'(TURNAROUND);
`endif

    // The counter is shared: reset stretch in RST, bus turnaround in RECLAIM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef Z80_PAD_BUS_FLOAT_EN
            ST_RUN: begin
                if (!bus.core_busak_n) begin
                    state_d = ST_FLOAT;
                end
            end
            ST_FLOAT: begin
                if (bus.core_busak_n) begin
                    if (TURNAROUND == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RECLAIM;
                        cnt_d   = TA_C;
                    end
                end
            end
            ST_RECLAIM: begin
                if (!bus.core_busak_n) begin
                    state_d = ST_FLOAT;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`else
            ST_RUN: state_d = ST_RUN;
`endif
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            cnt_q    <= RST_HOLD_C;
            resetN_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            resetN_q <= (state_d != ST_RST);
        end
    end

    assign core_reset_n = resetN_q;

`ifdef Z80_PAD_BUS_FLOAT_EN
    logic busFloating_q;

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            busFloating_q <= 1'b1;
        end else begin
            busFloating_q <= (state_d != ST_RUN);
        end
    end

    assign bus.bus_floating = busFloating_q;
    assign bus.io_oeb_addr  = {ADDR_W{busFloating_q}};
    assign bus.io_oeb_ctrl  = FLOAT_CTRL_MASK & {CTRL_W{busFloating_q}};
    assign bus.io_oeb_data  = {DATA_W{~(bus.core_doe & ~busFloating_q)}};
`else
    // Without bus float, /BUSAK and the turnaround setting have no effect.
    logic unusedBits;
    assign unusedBits = ^{bus.core_busak_n, CNT_W'(TURNAROUND), FLOAT_CTRL_MASK};

    assign bus.bus_floating = 1'b0;
    assign bus.io_oeb_addr  = '0;
    assign bus.io_oeb_ctrl  = '0;
    assign bus.io_oeb_data  = {DATA_W{~bus.core_doe}};
`endif

endmodule

// File: tb/tb_z80_pad_ctrl.sv
// Directed self-checking bench for z80_pad_ctrl; follows Z80_PAD_BUS_FLOAT_EN like the design.
module tb_z80_pad_ctrl;
    import z80_pad_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] padVec;
    logic       core_wait_n, core_int_n, core_nmi_n, core_busrq_n, core_reset_n;
    logic [3:0] coreVec;
    int         checks;
    int         failures;

    z80_pad_if busIf();

    z80_pad_ctrl u_dut (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .pad_wait_n  (padVec[0]),
        .pad_int_n   (padVec[1]),
        .pad_nmi_n   (padVec[2]),
        .pad_busrq_n (padVec[3]),
        .core_wait_n (core_wait_n),
        .core_int_n  (core_int_n),
        .core_nmi_n  (core_nmi_n),
        .core_busrq_n(core_busrq_n),
        .core_reset_n(core_reset_n),
        .bus         (busIf)
    );

    assign coreVec = {core_busrq_n, core_nmi_n, core_int_n, core_wait_n};

`ifdef Z80_PAD_BUS_FLOAT_EN
    logic     ta2Wait, ta2Int, ta2Nmi, ta2Busrq, ta2Reset;
    z80_pad_if busIf2();

    z80_pad_ctrl #(.TURNAROUND(2)) u_dut_ta2 (
        .wb_clk_i    (clk),
        .rst_n       (rst_n),
        .pad_wait_n  (padVec[0]),
        .pad_int_n   (padVec[1]),
        .pad_nmi_n   (padVec[2]),
        .pad_busrq_n (padVec[3]),
        .core_wait_n (ta2Wait),
        .core_int_n  (ta2Int),
        .core_nmi_n  (ta2Nmi),
        .core_busrq_n(ta2Busrq),
        .core_reset_n(ta2Reset),
        .bus         (busIf2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pads are driven low during reset so the synchroniser reset value is visible.
    task automatic test_reset();
        logic [15:0] expAddr;
        logic [7:0]  expCtrl;
        logic        expFloat;
`ifdef Z80_PAD_BUS_FLOAT_EN
        expAddr = 16'hFFFF; expCtrl = 8'h78; expFloat = 1'b1;
`else
        expAddr = 16'h0000; expCtrl = 8'h00; expFloat = 1'b0;
`endif
        rst_n = 1'b0;
        padVec = 4'b0000;
        busIf.core_busak_n = 1'b1;
        busIf.core_doe = 1'b0;
        repeat (3) tick();
        checks++;
        if (core_reset_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_core_reset_n got %b expected 0", core_reset_n);
        end
        checks++;
        if (coreVec !== 4'hF) begin
            failures++;
            $display("[TB] FAIL reset_sync_outputs got %h expected f", coreVec);
        end
        checks++;
        if (busIf.io_oeb_addr !== expAddr) begin
            failures++;
            $display("[TB] FAIL reset_oeb_addr got %h expected %h", busIf.io_oeb_addr, expAddr);
        end
        checks++;
        if (busIf.io_oeb_ctrl !== expCtrl) begin
            failures++;
            $display("[TB] FAIL reset_oeb_ctrl got %h expected %h", busIf.io_oeb_ctrl, expCtrl);
        end
        checks++;
        if (busIf.io_oeb_data !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_oeb_data got %h expected ff", busIf.io_oeb_data);
        end
        checks++;
        if (busIf.bus_floating !== expFloat) begin
            failures++;
            $display("[TB] FAIL reset_bus_floating got %b expected %b", busIf.bus_floating, expFloat);
        end
    endtask

    task automatic test_reset_stretch();
        rst_n = 1'b0;
        padVec = 4'hF;
        repeat (5) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (core_reset_n !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stretch_hold_%0d got %b expected 0", i, core_reset_n);
            end
`ifdef Z80_PAD_BUS_FLOAT_EN
            checks++;
            if (busIf.io_oeb_addr !== 16'hFFFF || busIf.io_oeb_ctrl !== 8'h78) begin
                failures++;
                $display("[TB] FAIL stretch_oeb_%0d got %h/%h expected ffff/78", i,
                         busIf.io_oeb_addr, busIf.io_oeb_ctrl);
            end
`endif
        end
        tick();
        checks++;
        if (core_reset_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stretch_release got %b expected 1", core_reset_n);
        end
        checks++;
        if (busIf.bus_floating !== 1'b0 || busIf.io_oeb_addr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL stretch_run_drive got %b/%h expected 0/0000",
                     busIf.bus_floating, busIf.io_oeb_addr);
        end
    endtask

    task automatic test_sync_latency();
        logic [3:0] pats [6];
        logic [3:0] prevPat;
        pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0101, 4'b1111};
        prevPat = 4'hF;
        for (int i = 0; i < 6; i++) begin
            padVec = pats[i];
            tick();
            checks++;
            if (coreVec !== prevPat) begin
                failures++;
                $display("[TB] FAIL sync_stage1_%0d got %b expected %b", i, coreVec, prevPat);
            end
            tick();
            checks++;
            if (coreVec !== pats[i]) begin
                failures++;
                $display("[TB] FAIL sync_stage2_%0d got %b expected %b", i, coreVec, pats[i]);
            end
            prevPat = pats[i];
        end
        // One-cycle low on /INT must come out as a one-cycle low.
        padVec[1] = 1'b0;
        tick();
        checks++;
        if (core_int_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL glitch_early got %b expected 1", core_int_n);
        end
        padVec[1] = 1'b1;
        tick();
        checks++;
        if (core_int_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL glitch_pulse got %b expected 0", core_int_n);
        end
        tick();
        checks++;
        if (core_int_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL glitch_end got %b expected 1", core_int_n);
        end
    endtask

    task automatic test_data_direction();
        busIf.core_doe = 1'b1;
        #1;
        checks++;
        if (busIf.io_oeb_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL data_write_run got %h expected 00", busIf.io_oeb_data);
        end
        busIf.core_doe = 1'b0;
        #1;
        checks++;
        if (busIf.io_oeb_data !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL data_read_run got %h expected ff", busIf.io_oeb_data);
        end
    endtask

`ifdef Z80_PAD_BUS_FLOAT_EN
    task automatic test_bus_grant();
        busIf.core_busak_n = 1'b0;
        tick();
        checks++;
        if (busIf.bus_floating !== 1'b1 || busIf.io_oeb_addr !== 16'hFFFF || busIf.io_oeb_ctrl !== 8'h78) begin
            failures++;
            $display("[TB] FAIL grant_float got %b/%h/%h expected 1/ffff/78",
                     busIf.bus_floating, busIf.io_oeb_addr, busIf.io_oeb_ctrl);
        end
        busIf.core_doe = 1'b1;
        #1;
        checks++;
        if (busIf.io_oeb_data !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL data_write_float got %h expected ff", busIf.io_oeb_data);
        end
        busIf.core_doe = 1'b0;
        busIf.core_busak_n = 1'b1;
        tick();
        checks++;
        if (busIf.io_oeb_addr !== 16'h0000 || busIf.io_oeb_ctrl !== 8'h00) begin
            failures++;
            $display("[TB] FAIL grant_return got %h/%h expected 0000/00",
                     busIf.io_oeb_addr, busIf.io_oeb_ctrl);
        end
    endtask

    task automatic test_turnaround();
        logic expF [3];
        expF = '{1'b1, 1'b1, 1'b0};
        busIf2.core_busak_n = 1'b0;
        tick();
        checks++;
        if (busIf2.bus_floating !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ta2_float got %b expected 1", busIf2.bus_floating);
        end
        busIf2.core_busak_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busIf2.bus_floating !== expF[i]) begin
                failures++;
                $display("[TB] FAIL ta2_release_%0d got %b expected %b", i + 1, busIf2.bus_floating, expF[i]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        busIf.core_busak_n = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (core_reset_n !== 1'b0 || busIf.io_oeb_addr !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL midgrant_rst got %b/%h expected 0/ffff", core_reset_n, busIf.io_oeb_addr);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (core_reset_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midgrant_hold got %b expected 0", core_reset_n);
        end
        tick();
        checks++;
        if (core_reset_n !== 1'b1 || busIf.bus_floating !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midgrant_run got %b/%b expected 1/0", core_reset_n, busIf.bus_floating);
        end
        tick();
        checks++;
        if (busIf.bus_floating !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midgrant_refloat got %b expected 1", busIf.bus_floating);
        end
        busIf.core_busak_n = 1'b1;
        tick();
    endtask
`else
    task automatic test_busak_ignored();
        busIf.core_busak_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busIf.bus_floating !== 1'b0 || busIf.io_oeb_addr !== 16'h0000 || busIf.io_oeb_ctrl !== 8'h00) begin
                failures++;
                $display("[TB] FAIL busak_nofloat_%0d got %b/%h/%h expected 0/0000/00", i,
                         busIf.bus_floating, busIf.io_oeb_addr, busIf.io_oeb_ctrl);
            end
        end
        busIf.core_doe = 1'b1;
        #1;
        checks++;
        if (busIf.io_oeb_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL busak_data_write got %h expected 00", busIf.io_oeb_data);
        end
        busIf.core_doe = 1'b0;
        busIf.core_busak_n = 1'b1;
        tick();
    endtask
`endif

    task automatic test_reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (core_reset_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pulse_enter got %b expected 0", core_reset_n);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (core_reset_n !== 1'b0) begin
                failures++;
                $display("[TB] FAIL pulse_hold_%0d got %b expected 0", i, core_reset_n);
            end
        end
        tick();
        checks++;
        if (core_reset_n !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pulse_release got %b expected 1", core_reset_n);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        padVec = 4'hF;
        busIf.core_busak_n = 1'b1;
        busIf.core_doe = 1'b0;
`ifdef Z80_PAD_BUS_FLOAT_EN
        busIf2.core_busak_n = 1'b1;
        busIf2.core_doe = 1'b0;
`endif
        $display("[TB] starting z80_pad_ctrl bench");
        test_reset();
        test_reset_stretch();
        test_sync_latency();
        test_data_direction();
`ifdef Z80_PAD_BUS_FLOAT_EN
        test_bus_grant();
        test_turnaround();
        test_reset_mid_grant();
`else
        test_busak_ignored();
`endif
        test_reset_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
